// File: rtl/mux2_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux2_arbiter_if
// Bundle of the request/data/handshake signals between two sources, the
// arbiter and the downstream consumer.
//   REQ0/REQ1 : source n has a beat on Dn (held until ACKn)
//   D0/D1     : source data, W bits
//   ACK0/ACK1 : source n beat accepted this cycle
//   Y         : muxed data, Y = S ? D1 : D0
//   VLD/RDY   : valid/ready toward the consumer
//   S         : registered mux select (1 selects D1)
//   BUSY      : a grant is active
// Handshake: a beat moves when VLD & RDY are both high at a rising clock
// edge; VLD never depends on RDY, and a source holds REQn/Dn until ACKn.
// master : the environment side (sources + consumer)
// slave  : the arbiter side
// ---------------------------------------------------------------------------
interface mux2_arbiter_if #(
    parameter int W = 8
);
    logic         REQ0;
    logic         REQ1;
    logic [W-1:0] D0;
    logic [W-1:0] D1;
    logic         ACK0;
    logic         ACK1;
    logic [W-1:0] Y;
    logic         VLD;
    logic         RDY;
    logic         S;
    logic         BUSY;

    modport master (
        output REQ0, REQ1, D0, D1, RDY,
        input  ACK0, ACK1, Y, VLD, S, BUSY
    );

    modport slave (
        input  REQ0, REQ1, D0, D1, RDY,
        output ACK0, ACK1, Y, VLD, S, BUSY
    );
endinterface

// File: rtl/mux2_arbiter.sv
// ---------------------------------------------------------------------------
// mux2_arbiter
// Two-requester round-robin arbiter with bounded bursts for a 2:1 mux
// datapath. The owner of the shared output Y is chosen per grant; each grant
// accepts at most MAX_BURST beats before the other source gets a turn.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   bus     : mux2_arbiter_if.slave (REQ/D/ACK, Y/VLD/RDY, S, BUSY)
//   state_o : debug view of the FSM state (0 IDLE, 1 GRANT0, 2 GRANT1)
// ---------------------------------------------------------------------------

// Single-bit 2:1 mux cell used to build the Y path.
module mux2_1 (
    input  logic a_i,
    input  logic b_i,
    input  logic s_i,
    output logic y_o
);
    assign y_o = s_i ? b_i : a_i;
endmodule

module mux2_arbiter #(
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    mux2_arbiter_if.slave bus,
    output logic [1:0]    state_o
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    state_t     state_q;
    logic       s_q;
    logic       last_q;
    logic [3:0] cnt_q;

    logic       req_own;
    logic       req_oth;
    logic       xfer;
    logic [3:0] cnt_d;
    logic       burst_done;

    // Requests seen from the point of view of the current grant holder.
    assign req_own = (state_q == GRANT1) ? bus.REQ1 : bus.REQ0;
    assign req_oth = (state_q == GRANT1) ? bus.REQ0 : bus.REQ1;

    // Nothing is offered or acknowledged during the reset cycle, so a beat
    // presented then is never half-accepted.
    assign bus.VLD  = ~rst & (((state_q == GRANT0) & bus.REQ0) |
                              ((state_q == GRANT1) & bus.REQ1));
    assign bus.ACK0 = ~rst & (state_q == GRANT0) & bus.REQ0 & bus.RDY;
    assign bus.ACK1 = ~rst & (state_q == GRANT1) & bus.REQ1 & bus.RDY;
    assign bus.BUSY = (state_q != IDLE);
    assign bus.S    = s_q;
    assign state_o  = state_q;

    assign xfer       = bus.VLD & bus.RDY;
    assign cnt_d      = cnt_q + 4'd1;
    assign burst_done = xfer & (cnt_d == MAX_B);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= 1'b0;
            last_q  <= 1'b1;    // source 0 wins the first tie
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.REQ0 & bus.REQ1) begin
                        state_q <= last_q ? GRANT0 : GRANT1;
                        s_q     <= ~last_q;
                        last_q  <= ~last_q;
                        cnt_q   <= 4'd0;
                    end else if (bus.REQ0) begin
                        state_q <= GRANT0;
                        s_q     <= 1'b0;
                        last_q  <= 1'b0;
                        cnt_q   <= 4'd0;
                    end else if (bus.REQ1) begin
                        state_q <= GRANT1;
                        s_q     <= 1'b1;
                        last_q  <= 1'b1;
                        cnt_q   <= 4'd0;
                    end
                end
                GRANT0, GRANT1: begin
                    if (!req_own || burst_done) begin
                        if (req_oth) begin
                            // Handover: state and S move together so Y
                            // switches source with no bubble.
                            state_q <= (state_q == GRANT0) ? GRANT1 : GRANT0;
                            s_q     <= ~s_q;
                            last_q  <= ~s_q;
                            cnt_q   <= 4'd0;
                        end else if (req_own) begin
                            // Burst exhausted with no competitor: re-grant.
                            cnt_q   <= 4'd0;
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= 4'd0;
                        end
                    end else if (xfer) begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_ymux
        mux2_1 u_mux (
            .a_i (bus.D0[i]),
            .b_i (bus.D1[i]),
            .s_i (s_q),
            .y_o (bus.Y[i])
        );
    end
endmodule
